// File: rtl/exec_pkg.sv
// Shared opcodes, flag bit positions and FSM states for the execute stage.
package exec_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_ADD  = 4'd0;
    localparam opcode_t OP_ADDC = 4'd1;
    localparam opcode_t OP_SUB  = 4'd2;
    localparam opcode_t OP_CMP  = 4'd3;
    localparam opcode_t OP_AND  = 4'd4;
    localparam opcode_t OP_OR   = 4'd5;
    localparam opcode_t OP_XOR  = 4'd6;
    localparam opcode_t OP_MOV  = 4'd7;
    localparam opcode_t OP_LSH  = 4'd8;
    localparam opcode_t OP_ASH  = 4'd9;
    localparam opcode_t OP_LUI  = 4'd10;
    localparam opcode_t OP_NOT  = 4'd11;
    localparam opcode_t OP_MUL  = 4'd12;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        WB   = 2'd3
    } state_t;

endpackage

// File: rtl/mul_iter.sv
// Shift-add multiplier: go loads operands, WIDTH iterations follow, done is high for one cycle after the last.
module mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic             running;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (go) begin
            acc     <= '0;
            mcand   <= b;
            mplier  <= a;
            cnt     <= CW'(WIDTH);
            running <= 1'b1;
        end else if (running) begin
            if (cnt != '0) begin
                acc    <= acc + (mplier[0] ? mcand : '0);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
            end else begin
                running <= 1'b0;
            end
        end
    end

    assign product = acc;
    assign done    = running && (cnt == '0);

endmodule

// File: rtl/exec_unit.sv
// Execute stage: computes b OP a for the register file and holds the {N,Z,F,L,C} flags.
// Optional iterative multiply for op 12 is built when EXEC_MUL_EN is defined.
module exec_unit
    import exec_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int OPBITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OPBITS-1:0] op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic [WIDTH-1:0]  result,
    output logic              regwrite,
    output logic              done,
    output logic              busy,
    output logic [4:0]        flags,
    output state_t            dbg_state
);
    // Handshake: a request is taken when start=1 while idle (busy=0); done pulses for
    // exactly one cycle with result valid; start is ignored from acceptance through done.
    state_t            state, state_nxt;
    logic [OPBITS-1:0] op_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic              wr_q;

    logic [WIDTH:0]    sum;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_wr;
    logic [4:0]        alu_flags;
    logic [5:0]        sh_mag;
    logic              sh_zero;
    logic              mul_done;
    logic [WIDTH-1:0]  mul_product;

`ifdef EXEC_MUL_EN
    mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .go      ((state == IDLE) && start && (op == OP_MUL)),
        .a       (a),
        .b       (b),
        .product (mul_product),
        .done    (mul_done)
    );
`else
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = EXEC;
`ifdef EXEC_MUL_EN
                    if (op == OP_MUL) state_nxt = MUL;
`endif
                end
            end
            EXEC:    state_nxt = WB;
            MUL:     if (mul_done) state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy      = (state != IDLE);
        done      = (state == WB);
        regwrite  = (state == WB) && wr_q;
        dbg_state = state;
    end

    // Shift amount is the signed 5-bit field of a; -16 needs the sixth magnitude bit.
    always_comb begin
        sh_mag  = a_q[4] ? (6'd0 - {a_q[4], a_q[4:0]}) : {1'b0, a_q[4:0]};
        sh_zero = (sh_mag >= 6'(WIDTH));
        sum       = '0;
        alu_res   = result;
        alu_wr    = 1'b1;
        alu_flags = flags;
        case (op_q)
            OP_ADD, OP_ADDC: begin
                sum = {1'b0, b_q} + {1'b0, a_q}
                    + {{WIDTH{1'b0}}, (op_q == OP_ADDC) && flags[FLAG_C]};
                alu_res           = sum[WIDTH-1:0];
                alu_flags[FLAG_C] = sum[WIDTH];
                alu_flags[FLAG_F] = (b_q[WIDTH-1] == a_q[WIDTH-1]) && (sum[WIDTH-1] != b_q[WIDTH-1]);
            end
            OP_SUB: begin
                sum = {1'b0, b_q} - {1'b0, a_q};
                alu_res           = sum[WIDTH-1:0];
                alu_flags[FLAG_C] = sum[WIDTH];
                alu_flags[FLAG_F] = (b_q[WIDTH-1] != a_q[WIDTH-1]) && (sum[WIDTH-1] != b_q[WIDTH-1]);
            end
            OP_CMP: begin
                alu_wr            = 1'b0;
                alu_flags[FLAG_L] = (b_q < a_q);
                alu_flags[FLAG_N] = ($signed(b_q) < $signed(a_q));
                alu_flags[FLAG_Z] = (b_q == a_q);
            end
            OP_AND: alu_res = b_q & a_q;
            OP_OR:  alu_res = b_q | a_q;
            OP_XOR: alu_res = b_q ^ a_q;
            OP_MOV: alu_res = a_q;
            OP_NOT: alu_res = ~a_q;
            OP_LUI: alu_res = WIDTH'({a_q[7:0], 8'h00});
            OP_LSH: begin
                if (sh_zero)     alu_res = '0;
                else if (a_q[4]) alu_res = b_q >> sh_mag;
                else             alu_res = b_q << sh_mag;
            end
            OP_ASH: begin
                if (sh_zero)     alu_res = '0;
                else if (a_q[4]) alu_res = $signed(b_q) >>> sh_mag;
                else             alu_res = b_q << sh_mag;
            end
            default: alu_wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            wr_q   <= 1'b0;
            flags  <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
            end
            if (state == EXEC) begin
                result <= alu_res;
                wr_q   <= alu_wr;
                flags  <= alu_flags;
            end else if ((state == MUL) && mul_done) begin
                result <= mul_product;
                wr_q   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit; MUL vectors are used when EXEC_MUL_EN is defined.
module tb_exec_unit;
    import exec_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic         regwrite;
    logic         done;
    logic         busy;
    logic [4:0]   flags;
    state_t       dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    exec_unit #(.WIDTH(W), .OPBITS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .result    (result),
        .regwrite  (regwrite),
        .done      (done),
        .busy      (busy),
        .flags     (flags),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one op in an idle cycle, then follow it to its done cycle (sampled on negedges).
    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] bv,
                          input logic [W-1:0] av, input logic [W-1:0] e_res, input logic e_wr,
                          input logic [4:0] e_flags, input int e_lat);
        int lat;
        logic [W-1:0] e;
        exp_q.push_back(e_res);
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        check({tag, "_lat"}, lat, e_lat);
        if (lat != 0) begin
            check({tag, "_res"}, result, e);
            check({tag, "_wr"}, regwrite, e_wr);
            check({tag, "_flags"}, flags, e_flags);
            @(negedge clk);
            check({tag, "_done_pulse"}, done, 0);
        end
    endtask

    // Hold start high with a different op while busy; only the first request may complete.
    task automatic ignore_test(input logic [3:0] o, input logic [W-1:0] bv, input logic [W-1:0] av,
                               input logic [W-1:0] e_res);
        int nd;
        logic [W-1:0] r;
        nd = 0;
        r  = '0;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        op = OP_MOV; a = 16'h0009;
        for (int i = 1; i <= 30; i++) begin
            if (done) begin
                nd++;
                r = result;
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("ignore_done_count", nd, 1);
        check("ignore_res", r, e_res);
    endtask

    initial begin
        int nd;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_result", result, 0);
        check("rst_done", done, 0);
        check("rst_regwrite", regwrite, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", flags, 0);
        check("rst_state", dbg_state, IDLE);
        reset = 1'b0;

        // flags packed as {N,Z,F,L,C}
        run_op("add_ovf",   OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 1, 5'h04, 2);
        run_op("add_carry", OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1, 5'h01, 2);
        run_op("addc",      OP_ADDC, 16'h0002, 16'h0003, 16'h0006, 1, 5'h00, 2);
        run_op("cmp_lt_u",  OP_CMP,  16'h0001, 16'hFFFF, 16'h0006, 0, 5'h02, 2);
        run_op("cmp_eq",    OP_CMP,  16'h0008, 16'h0008, 16'h0006, 0, 5'h08, 2);
        run_op("cmp_lt_s",  OP_CMP,  16'hFFFF, 16'h0001, 16'h0006, 0, 5'h10, 2);
        run_op("sub_brw",   OP_SUB,  16'h0005, 16'h0007, 16'hFFFE, 1, 5'h11, 2);
        run_op("sub_ovf",   OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 1, 5'h14, 2);
        run_op("lsh_r4",    OP_LSH,  16'h00F0, 16'hFFFC, 16'h000F, 1, 5'h14, 2);
        run_op("ash_r15",   OP_ASH,  16'h8000, 16'hFFF1, 16'hFFFF, 1, 5'h14, 2);
        run_op("lsh_16",    OP_LSH,  16'h1234, 16'h0010, 16'h0000, 1, 5'h14, 2);
        run_op("lsh_l3",    OP_LSH,  16'h0001, 16'h0003, 16'h0008, 1, 5'h14, 2);
        run_op("ash_l4",    OP_ASH,  16'h0F0F, 16'h0004, 16'hF0F0, 1, 5'h14, 2);
        run_op("lui",       OP_LUI,  16'h5555, 16'h12AB, 16'hAB00, 1, 5'h14, 2);
        run_op("and",       OP_AND,  16'hF0F0, 16'hFF00, 16'hF000, 1, 5'h14, 2);
        run_op("or",        OP_OR,   16'hF0F0, 16'hFF00, 16'hFFF0, 1, 5'h14, 2);
        run_op("xor",       OP_XOR,  16'hF0F0, 16'hFF00, 16'h0FF0, 1, 5'h14, 2);
        run_op("mov",       OP_MOV,  16'hAAAA, 16'h1357, 16'h1357, 1, 5'h14, 2);
        run_op("not",       OP_NOT,  16'hAAAA, 16'h00FF, 16'hFF00, 1, 5'h14, 2);
        run_op("rsvd14",    4'd14,   16'h0001, 16'h0001, 16'hFF00, 0, 5'h14, 2);
`ifdef EXEC_MUL_EN
        run_op("mul",       OP_MUL,  16'd300,  16'd300,  16'h5F90, 1, 5'h14, 18);
        ignore_test(OP_MUL, 16'h0003, 16'h0005, 16'h000F);
        check("ignore_flags", flags, 5'h14);
`else
        run_op("op12_rsvd", OP_MUL,  16'd300,  16'd300,  16'hFF00, 0, 5'h14, 2);
        ignore_test(OP_ADD, 16'h0001, 16'h0001, 16'h0002);
        check("ignore_flags", flags, 5'h10);
`endif

        // Reset in the middle of an operation must abort it without a write.
        @(negedge clk);
        start = 1'b1; a = 16'h0003; b = 16'h0005;
`ifdef EXEC_MUL_EN
        op = OP_MUL;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
`else
        op = OP_ADD;
        @(negedge clk);
        start = 1'b0;
`endif
        reset = 1'b1;
        @(negedge clk);
        check("midrst_result", result, 0);
        check("midrst_flags", flags, 0);
        check("midrst_busy", busy, 0);
        check("midrst_state", dbg_state, IDLE);
        reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 25; i++) begin
            if (done || regwrite) nd++;
            @(negedge clk);
        end
        check("midrst_no_done", nd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
